// File: rtl/bit_serializer_pkg.sv
// Shared definitions for bit_serializer: state encoding, default word width and
// the frame-length helper (data bits plus an optional even-parity bit).
// Optional feature macro: BIT_SERIALIZER_PARITY_EN.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Number of serial bits emitted per accepted word.
    function automatic int FRAME_LEN(input int width);
`ifdef BIT_SERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the "1101" sequence detector.
// Latency: first bit on ser_out the cycle after the handshake; back-to-back words with no gap.
// Backpressure: data_ready high in IDLE and on the final bit of a frame only; upstream holds data otherwise.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   data_in/_valid/_ready  word input handshake (word sampled on data_valid && data_ready)
//   ser_out, ser_valid  serial bit stream and its qualifier
//   last                current ser_out bit is the final bit of the frame
// Optional feature macro: BIT_SERIALIZER_PARITY_EN appends an even-parity bit to each frame.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last
);

    localparam int FRAME = FRAME_LEN(WIDTH);
    localparam int CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [FRAME-1:0] sreg_q, sreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             last_q, last_d;

    logic [FRAME-1:0] frame_w;
    logic             at_last_w;
    logic             load_w;

    // Frame laid out in transmit order: frame_w[0] goes out first.
    always_comb begin
        frame_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            frame_w[i] = (MSB_FIRST != 0) ? data_in[WIDTH-1-i] : data_in[i];
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        frame_w[WIDTH] = ^data_in;
`endif
    end

    assign at_last_w  = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    assign data_ready = (state_q == IDLE) || at_last_w;
    assign load_w     = data_valid && data_ready;

    // The first bit goes straight into the output register on load; the shift
    // register only holds the bits still to come, so bit k+1 is always at sreg_q[0].
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        last_d      = last_q;

        if (load_w) begin
            // Covers both the IDLE start and the gapless reload on the final bit.
            state_d     = SHIFT;
            cnt_d       = '0;
            sreg_d      = frame_w >> 1;
            ser_out_d   = frame_w[0];
            ser_valid_d = 1'b1;
            last_d      = 1'b0;
        end else if (state_q == SHIFT) begin
            if (at_last_w) begin
                state_d     = IDLE;
                cnt_d       = '0;
                sreg_d      = '0;
                ser_out_d   = 1'b0;
                ser_valid_d = 1'b0;
                last_d      = 1'b0;
            end else begin
                cnt_d     = cnt_q + CW'(1);
                sreg_d    = sreg_q >> 1;
                ser_out_d = sreg_q[0];
                last_d    = (cnt_q + CW'(1)) == LAST_IDX;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sreg_q      <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            last_q      <= last_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign last      = last_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: an MSB-first and an LSB-first instance
// share one input stream; a queue-based frame model predicts every output cycle.
module tb_bit_serializer;

    localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         m_rdy, m_out, m_val, m_last;
    logic         l_rdy, l_out, l_val, l_last;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(m_rdy), .ser_out(m_out), .ser_valid(m_val), .last(m_last)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(l_rdy), .ser_out(l_out), .ser_valid(l_val), .last(l_last)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each queue holds the bits still to be shown, head = bit on ser_out now.
    bit qm[$];
    bit ql[$];
    bit m_acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qm.delete();
            ql.delete();
        end else begin
            m_acc = data_valid && (qm.size() <= 1);
            if (qm.size() != 0) void'(qm.pop_front());
            if (ql.size() != 0) void'(ql.pop_front());
            if (m_acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(data_in[W-1-i]);
                    ql.push_back(data_in[i]);
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                qm.push_back(^data_in);
                ql.push_back(^data_in);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("msb_valid", 32'(m_val),  32'(qm.size() != 0));
            check("msb_out",   32'(m_out),  32'((qm.size() != 0) ? qm[0] : 1'b0));
            check("msb_last",  32'(m_last), 32'(qm.size() == 1));
            check("msb_ready", 32'(m_rdy),  32'(qm.size() <= 1));
            check("lsb_valid", 32'(l_val),  32'(ql.size() != 0));
            check("lsb_out",   32'(l_out),  32'((ql.size() != 0) ? ql[0] : 1'b0));
            check("lsb_last",  32'(l_last), 32'(ql.size() == 1));
            check("lsb_ready", 32'(l_rdy),  32'(ql.size() <= 1));
        end
    end

    // Captured per-cycle observations for hand-computed literal checks.
    bit cm[32], cl[32], clast[32], crdy[32], cval[32];

    task automatic wait_accept();
        int n = 0;
        while (!m_rdy && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic capture(input int n, input int drop_at, input logic [W-1:0] nxt);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cm[i] = m_out; cl[i] = l_out; clast[i] = m_last; crdy[i] = m_rdy; cval[i] = m_val;
            #1;
            if (i == 0) data_in = nxt;
            if (i == drop_at) data_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        @(negedge clk);
        #1;
        data_valid = 1'b1;
        data_in    = w;
        #1;
        wait_accept();
    endtask

    function automatic logic [31:0] pack(input int sel, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) begin
            case (sel)
                0: r = {r[30:0], cm[i]};
                1: r = {r[30:0], cl[i]};
                2: r = {r[30:0], clast[i]};
                3: r = {r[30:0], crdy[i]};
                default: r = {r[30:0], cval[i]};
            endcase
        end
        return r;
    endfunction

    // Overlapping "1101" count over the captured MSB-first stream.
    function automatic int det_count(input int n);
        int c = 0;
        for (int i = 0; i + 3 < n; i++)
            if (cm[i] && cm[i+1] && !cm[i+2] && cm[i+3]) c++;
        return c;
    endfunction

    logic [31:0] e_d0, e_0b, e_b2b, e_b2b_last, e_0f_m, e_0f_l, e_c0;
    int          e_b2b_det;
    logic        hold_rdy;

    initial begin
`ifdef BIT_SERIALIZER_PARITY_EN
        e_d0 = 32'h1A1; e_0b = 32'h017; e_b2b = {14'd0, 8'hDD, 1'b0, 8'hB0, 1'b1};
        e_b2b_last = 32'h201; e_b2b_det = 2; e_0f_m = 32'h01E; e_0f_l = 32'h1E0; e_c0 = 32'h180;
`else
        e_d0 = 32'hD0; e_0b = 32'h0B; e_b2b = 32'hDDB0;
        e_b2b_last = 32'h0101; e_b2b_det = 3; e_0f_m = 32'h0F; e_0f_l = 32'hF0; e_c0 = 32'hC0;
`endif
        reset = 1'b1; data_valid = 1'b0; data_in = '0;
        started = 1'b1;
        #3;
        check("rst_ready", 32'(m_rdy), 32'd1);
        check("rst_valid", 32'(m_val), 32'd0);
        check("rst_out",   32'(m_out), 32'd0);
        check("rst_last",  32'(m_last), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // MSB-first 0xD0 / LSB-first view of the same word.
        send(8'hD0);
        capture(FRAME, 0, 8'h00);
        check("d0_msb_stream", pack(0, FRAME), e_d0);
        check("d0_lsb_stream", pack(1, FRAME), e_0b);
        check("d0_ready_pat",  pack(3, FRAME), 32'd1);
        check("d0_last_pat",   pack(2, FRAME), 32'd1);
        check("d0_valid_pat",  pack(4, FRAME), (32'd1 << FRAME) - 32'd1);
        check("d0_detect",     32'(det_count(FRAME)), 32'd1);

        // LSB-first 0x0B yields 1,1,0,1,0,0,0,0.
        send(8'h0B);
        capture(FRAME, 0, 8'h00);
        check("0b_lsb_stream", pack(1, FRAME), e_d0);
        check("0b_msb_stream", pack(0, FRAME), e_0b);

        // Back-to-back 0xDD then 0xB0, no gap between frames.
        send(8'hDD);
        capture(2 * FRAME, FRAME, 8'hB0);
        check("b2b_stream", pack(0, 2 * FRAME), e_b2b);
        check("b2b_valid",  pack(4, 2 * FRAME), (32'd1 << (2 * FRAME)) - 32'd1);
        check("b2b_last",   pack(2, 2 * FRAME), e_b2b_last);
        check("b2b_detect", 32'(det_count(2 * FRAME)), 32'(e_b2b_det));

        // Reset asserted during bit 3 of 0xFF: outputs drop without a clock edge.
        send(8'hFF);
        capture(3, 0, 8'hFF);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'({m_val, l_val}),   32'd0);
        check("mid_rst_out",   32'({m_out, l_out}),   32'd0);
        check("mid_rst_last",  32'({m_last, l_last}), 32'd0);
        check("mid_rst_ready", 32'({m_rdy, l_rdy}),   32'd3);
        @(negedge clk);
        #1 reset = 1'b0;
        send(8'h0F);
        capture(FRAME, 0, 8'h00);
        check("post_rst_msb", pack(0, FRAME), e_0f_m);
        check("post_rst_lsb", pack(1, FRAME), e_0f_l);

        send(8'hC0);
        capture(FRAME, 0, 8'h00);
        check("c0_msb_stream", pack(0, FRAME), e_c0);

        // Upstream stall: five idle cycles, then immediate load.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(m_val), 32'd0);
            check("stall_out",   32'(m_out), 32'd0);
            check("stall_ready", 32'(m_rdy), 32'd1);
        end
        #1 data_valid = 1'b1; data_in = 8'hA5;
        @(negedge clk);
        check("stall_load_valid", 32'(m_val), 32'd1);
        check("stall_load_bit",   32'(m_out), 32'd1);
        #1 data_valid = 1'b0;
        repeat (FRAME + 2) @(negedge clk);

        // Random traffic; a word offered while not ready is held until accepted.
        hold_rdy = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (!(data_valid && !hold_rdy)) begin
                data_valid = ($urandom_range(0, 3) != 0);
                data_in    = W'($urandom);
            end
            #1 hold_rdy = m_rdy;
        end
        #1 data_valid = 1'b0;
        repeat (2 * FRAME + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
